// File: rtl/spoc_block_assembler.sv
// rtl/spoc_block_assembler.sv - SpoC rate-block assembler: bdi word packing, 10* padding, truncated bdo streaming
module spoc_block_assembler #(
    parameter  int PW         = 32,
    parameter  int RATE_BYTES = 8,
    localparam int WORDS      = RATE_BYTES * 8 / PW,
    localparam int SZW        = $clog2(PW / 8) + 1,
    localparam int BCW        = $clog2(RATE_BYTES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PW-1:0]             bdi,
    input  logic                      bdi_valid,
    output logic                      bdi_ready,
    input  logic [SZW-1:0]            bdi_size,
    input  logic                      bdi_eot,
    input  logic [3:0]                bdi_type,
    input  logic                      decrypt,
    input  logic [RATE_BYTES*8-1:0]   ks,
    output logic [RATE_BYTES*8-1:0]   blk,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic                      blk_partial,
    output logic [BCW-1:0]            blk_bytes,
    output logic [3:0]                blk_type,
    output logic [PW-1:0]             bdo,
    output logic                      bdo_valid,
    input  logic                      bdo_ready,
    output logic [SZW-1:0]            bdo_size
);

    localparam int PWB = PW / 8;
    localparam int RB  = RATE_BYTES * 8;
    localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RB-1:0]    buffer;
    logic [RB-1:0]    out_reg;
    logic [WCW-1:0]   word_ctr;
    logic [WCW-1:0]   out_ctr;
    logic [BCW-1:0]   byte_ctr;
    logic [3:0]       type_q;

    logic             bdi_hs, blk_hs, bdo_hs;
    logic             is_msg;
    logic             last_slot;
    logic             last_out;
    logic [PW-1:0]    word_masked;
    logic [RB-1:0]    rate_mask;
    logic [RB-1:0]    xored;
    logic [RB-1:0]    data;
    logic [RB-1:0]    blk_c;
    logic [BCW-1:0]   rem;
    logic [SZW-1:0]   out_size;
    logic [PW-1:0]    out_word;
    logic [PW-1:0]    out_masked;

    assign bdi_hs    = bdi_valid & bdi_ready;
    assign blk_hs    = blk_valid & blk_ready;
    assign bdo_hs    = bdo_valid & bdo_ready;
    assign is_msg    = (type_q[3:1] == 3'b010);
    assign last_slot = (word_ctr == WCW'(WORDS - 1));

    // Incoming word: keep the first bdi_size bytes counted from the MSB
    always_comb begin
        word_masked = '0;
        for (int b = 0; b < PWB; b++) begin
            if (SZW'(b) < bdi_size)
                word_masked[(PWB-1-b)*8 +: 8] = bdi[(PWB-1-b)*8 +: 8];
        end
    end

    always_comb begin
        rate_mask = '0;
        for (int b = 0; b < RATE_BYTES; b++) begin
            if (BCW'(b) < byte_ctr)
                rate_mask[(RATE_BYTES-1-b)*8 +: 8] = 8'hFF;
        end
    end

    assign xored = buffer ^ (ks & rate_mask);
    assign data  = (decrypt && is_msg) ? xored : buffer;

    // Data bytes, then a single 0x80 pad byte, then zeros
    always_comb begin
        blk_c = '0;
        for (int b = 0; b < RATE_BYTES; b++) begin
            if (BCW'(b) < byte_ctr)
                blk_c[(RATE_BYTES-1-b)*8 +: 8] = data[(RATE_BYTES-1-b)*8 +: 8];
            else if (BCW'(b) == byte_ctr)
                blk_c[(RATE_BYTES-1-b)*8 +: 8] = 8'h80;
        end
    end

    assign rem      = byte_ctr - (BCW'(out_ctr) * BCW'(PWB));
    assign out_size = (rem < BCW'(PWB)) ? SZW'(rem) : SZW'(PWB);
    assign last_out = (rem <= BCW'(PWB));

    always_comb begin
        out_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (WCW'(w) == out_ctr)
                out_word = out_reg[(WORDS-1-w)*PW +: PW];
        end
    end

    always_comb begin
        out_masked = '0;
        for (int b = 0; b < PWB; b++) begin
            if (SZW'(b) < out_size)
                out_masked[(PWB-1-b)*8 +: 8] = out_word[(PWB-1-b)*8 +: 8];
        end
    end

    assign blk         = blk_c;
    assign blk_bytes   = byte_ctr;
    assign blk_partial = (byte_ctr < BCW'(RATE_BYTES));
    assign blk_type    = type_q;

    always_comb begin
        state_d   = state_q;
        bdi_ready = 1'b0;
        blk_valid = 1'b0;
        bdo_valid = 1'b0;
        bdo       = '0;
        bdo_size  = '0;
        case (state_q)
            FILL: begin
                bdi_ready = 1'b1;
                if (bdi_hs && (bdi_eot || last_slot))
                    state_d = HOLD;
            end
            HOLD: begin
                blk_valid = 1'b1;
                if (blk_hs)
                    state_d = (is_msg && byte_ctr != '0) ? EMIT : FILL;
            end
            EMIT: begin
                bdo_valid = 1'b1;
                bdo       = out_masked;
                bdo_size  = out_size;
                if (bdo_hs && last_out)
                    state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            buffer   <= '0;
            out_reg  <= '0;
            word_ctr <= '0;
            out_ctr  <= '0;
            byte_ctr <= '0;
            type_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FILL: begin
                    if (bdi_hs) begin
                        for (int w = 0; w < WORDS; w++) begin
                            if (WCW'(w) == word_ctr)
                                buffer[(WORDS-1-w)*PW +: PW] <= word_masked;
                        end
                        byte_ctr <= byte_ctr + BCW'(bdi_size);
                        if (word_ctr == '0)
                            type_q <= bdi_type;
                        word_ctr <= (bdi_eot || last_slot) ? '0 : word_ctr + WCW'(1);
                    end
                end
                HOLD: begin
                    if (blk_hs) begin
                        // out_reg decouples the output stream from ks so state may advance
                        if (is_msg && byte_ctr != '0) begin
                            out_reg <= xored;
                            out_ctr <= '0;
                        end else begin
                            byte_ctr <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (bdo_hs) begin
                        if (last_out) begin
                            out_ctr  <= '0;
                            byte_ctr <= '0;
                        end else begin
                            out_ctr <= out_ctr + WCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spoc_block_assembler.sv
// tb/tb_spoc_block_assembler.sv - directed bench for spoc_block_assembler at PW=32/R=8 and PW=64/R=16
module tb_spoc_block_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // 32-bit / 8-byte unit
    logic        rst32;
    logic [31:0] bdi32;
    logic        bdi_valid32, bdi_ready32, bdi_eot32, decrypt32;
    logic [2:0]  bdi_size32;
    logic [3:0]  bdi_type32;
    logic [63:0] ks32, blk32;
    logic        blk_valid32, blk_ready32, blk_partial32;
    logic [3:0]  blk_bytes32, blk_type32;
    logic [31:0] bdo32;
    logic        bdo_valid32, bdo_ready32;
    logic [2:0]  bdo_size32;

    // 64-bit / 16-byte unit
    logic         rst64;
    logic [63:0]  bdi64;
    logic         bdi_valid64, bdi_ready64, bdi_eot64, decrypt64;
    logic [3:0]   bdi_size64;
    logic [3:0]   bdi_type64;
    logic [127:0] ks64, blk64;
    logic         blk_valid64, blk_ready64, blk_partial64;
    logic [4:0]   blk_bytes64;
    logic [3:0]   blk_type64;
    logic [63:0]  bdo64;
    logic         bdo_valid64, bdo_ready64;
    logic [3:0]   bdo_size64;

    spoc_block_assembler #(.PW(32), .RATE_BYTES(8)) u_dut32 (
        .clk(clk), .rst(rst32),
        .bdi(bdi32), .bdi_valid(bdi_valid32), .bdi_ready(bdi_ready32),
        .bdi_size(bdi_size32), .bdi_eot(bdi_eot32), .bdi_type(bdi_type32),
        .decrypt(decrypt32), .ks(ks32),
        .blk(blk32), .blk_valid(blk_valid32), .blk_ready(blk_ready32),
        .blk_partial(blk_partial32), .blk_bytes(blk_bytes32), .blk_type(blk_type32),
        .bdo(bdo32), .bdo_valid(bdo_valid32), .bdo_ready(bdo_ready32), .bdo_size(bdo_size32)
    );

    spoc_block_assembler #(.PW(64), .RATE_BYTES(16)) u_dut64 (
        .clk(clk), .rst(rst64),
        .bdi(bdi64), .bdi_valid(bdi_valid64), .bdi_ready(bdi_ready64),
        .bdi_size(bdi_size64), .bdi_eot(bdi_eot64), .bdi_type(bdi_type64),
        .decrypt(decrypt64), .ks(ks64),
        .blk(blk64), .blk_valid(blk_valid64), .blk_ready(blk_ready64),
        .blk_partial(blk_partial64), .blk_bytes(blk_bytes64), .blk_type(blk_type64),
        .bdo(bdo64), .bdo_valid(bdo_valid64), .bdo_ready(bdo_ready64), .bdo_size(bdo_size64)
    );

    always @(posedge clk) begin
        assert (!(bdi_valid32 && bdi_size32 > 3'd4)) else $error("illegal bdi_size on 32-bit unit");
        assert (!(bdi_valid64 && bdi_size64 > 4'd8)) else $error("illegal bdi_size on 64-bit unit");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send32(input logic [31:0] w, input logic [2:0] sz, input logic eot, input logic [3:0] ty);
        int n = 0;
        bdi32 = w; bdi_size32 = sz; bdi_eot32 = eot; bdi_type32 = ty; bdi_valid32 = 1'b1;
        while (!bdi_ready32 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("send32_ready_timeout", bdi_ready32, 1'b1);
        @(posedge clk); #1;
        bdi_valid32 = 1'b0;
    endtask

    task automatic take_blk32(input string tag, input logic [63:0] eb, input logic [3:0] ebytes, input logic epart);
        check({tag, "_blk_valid"}, blk_valid32, 1'b1);
        check({tag, "_blk"}, blk32, eb);
        check({tag, "_blk_bytes"}, blk_bytes32, ebytes);
        check({tag, "_blk_partial"}, blk_partial32, epart);
        blk_ready32 = 1'b1;
        @(posedge clk); #1;
        blk_ready32 = 1'b0;
    endtask

    task automatic take_bdo32(input string tag, input logic [31:0] ew, input logic [2:0] esz);
        int n = 0;
        while (!bdo_valid32 && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "_bdo_valid"}, bdo_valid32, 1'b1);
        check({tag, "_bdo"}, bdo32, ew);
        check({tag, "_bdo_size"}, bdo_size32, esz);
        bdo_ready32 = 1'b1;
        @(posedge clk); #1;
        bdo_ready32 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] w, input logic [3:0] sz, input logic eot, input logic [3:0] ty);
        int n = 0;
        bdi64 = w; bdi_size64 = sz; bdi_eot64 = eot; bdi_type64 = ty; bdi_valid64 = 1'b1;
        while (!bdi_ready64 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("send64_ready_timeout", bdi_ready64, 1'b1);
        @(posedge clk); #1;
        bdi_valid64 = 1'b0;
    endtask

    task automatic take_bdo64(input string tag, input logic [63:0] ew, input logic [3:0] esz);
        int n = 0;
        while (!bdo_valid64 && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "_bdo_valid"}, bdo_valid64, 1'b1);
        check({tag, "_bdo"}, bdo64, ew);
        check({tag, "_bdo_size"}, bdo_size64, esz);
        bdo_ready64 = 1'b1;
        @(posedge clk); #1;
        bdo_ready64 = 1'b0;
    endtask

    initial begin
        rst32 = 1'b1; bdi32 = '0; bdi_valid32 = 1'b0; bdi_size32 = '0; bdi_eot32 = 1'b0;
        bdi_type32 = '0; decrypt32 = 1'b0; ks32 = '0; blk_ready32 = 1'b0; bdo_ready32 = 1'b0;
        rst64 = 1'b1; bdi64 = '0; bdi_valid64 = 1'b0; bdi_size64 = '0; bdi_eot64 = 1'b0;
        bdi_type64 = '0; decrypt64 = 1'b0; ks64 = '0; blk_ready64 = 1'b0; bdo_ready64 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst32 = 1'b0; rst64 = 1'b0;

        check("rst_bdi_ready", bdi_ready32, 1'b1);
        check("rst_blk_valid", blk_valid32, 1'b0);
        check("rst_bdo_valid", bdo_valid32, 1'b0);
        check("rst_bdo", bdo32, 32'h0);
        check("rst_bdo_size", bdo_size32, 3'd0);

        // AD, full block
        send32(32'h01020304, 3'd4, 1'b0, 4'b0001);
        check("ad_mid_blk_valid", blk_valid32, 1'b0);
        send32(32'h05060708, 3'd4, 1'b1, 4'b0001);
        take_blk32("ad_full", 64'h0102030405060708, 4'd8, 1'b0);
        check("ad_full_no_bdo", bdo_valid32, 1'b0);
        check("ad_full_ready", bdi_ready32, 1'b1);

        // AD partial
        send32(32'hAABBCCDD, 3'd3, 1'b1, 4'b0001);
        check("ad_part_type", blk_type32, 4'b0001);
        take_blk32("ad_part", 64'hAABBCC8000000000, 4'd3, 1'b1);
        check("ad_part_no_bdo", bdo_valid32, 1'b0);

        // PT encrypt
        ks32 = 64'hF0F0F0F00F0F0F0F;
        decrypt32 = 1'b0;
        send32(32'h11223344, 3'd4, 1'b0, 4'b0100);
        send32(32'h55000000, 3'd1, 1'b1, 4'b0100);
        take_blk32("pt_enc", 64'h1122334455800000, 4'd5, 1'b1);
        take_bdo32("pt_enc_w0", 32'hE1D2C3B4, 3'd4);
        take_bdo32("pt_enc_w1", 32'h5A000000, 3'd1);
        check("pt_enc_done_ready", bdi_ready32, 1'b1);
        check("pt_enc_done_bdo", bdo_valid32, 1'b0);

        // CT decrypt
        decrypt32 = 1'b1;
        send32(32'hE1D2C3B4, 3'd4, 1'b0, 4'b0101);
        send32(32'h5A000000, 3'd1, 1'b1, 4'b0101);
        take_blk32("ct_dec", 64'h1122334455800000, 4'd5, 1'b1);
        take_bdo32("ct_dec_w0", 32'h11223344, 3'd4);
        take_bdo32("ct_dec_w1", 32'h55000000, 3'd1);
        decrypt32 = 1'b0;

        // Empty PT segment
        send32(32'h00000000, 3'd0, 1'b1, 4'b0100);
        take_blk32("pt_empty", 64'h8000000000000000, 4'd0, 1'b1);
        check("pt_empty_ready", bdi_ready32, 1'b1);
        check("pt_empty_no_bdo", bdo_valid32, 1'b0);

        // 64-bit unit: full block from two words, stalled absorb
        ks64 = 128'hFFFFFFFFFFFFFFFF_0000000000000000;
        send64(64'h0011223344556677, 4'd8, 1'b0, 4'b0100);
        send64(64'h8899AABBCCDDEEFF, 4'd8, 1'b0, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            check("w64_stall_blk", blk64, 128'h0011223344556677_8899AABBCCDDEEFF);
            check("w64_stall_bdi_ready", bdi_ready64, 1'b0);
            @(posedge clk); #1;
        end
        check("w64_full_valid", blk_valid64, 1'b1);
        check("w64_full_bytes", blk_bytes64, 5'd16);
        check("w64_full_partial", blk_partial64, 1'b0);
        blk_ready64 = 1'b1;
        @(posedge clk); #1;
        blk_ready64 = 1'b0;
        take_bdo64("w64_full_w0", 64'hFFEEDDCCBBAA9988, 4'd8);
        take_bdo64("w64_full_w1", 64'h8899AABBCCDDEEFF, 4'd8);

        // Third word opens a new block
        send64(64'h0123456789ABCDEF, 4'd8, 1'b0, 4'b0100);
        check("w64_open_blk_valid", blk_valid64, 1'b0);
        check("w64_open_bdi_ready", bdi_ready64, 1'b1);
        send64(64'hA1A2A3A4A5A6A7A8, 4'd2, 1'b1, 4'b0100);
        check("w64_part_blk", blk64, 128'h0123456789ABCDEF_A1A2800000000000);
        check("w64_part_bytes", blk_bytes64, 5'd10);
        check("w64_part_partial", blk_partial64, 1'b1);
        check("w64_part_type", blk_type64, 4'b0100);
        blk_ready64 = 1'b1;
        @(posedge clk); #1;
        blk_ready64 = 1'b0;
        check("w64_emit_valid", bdo_valid64, 1'b1);
        check("w64_emit_bdo", bdo64, 64'hFEDCBA9876543210);

        // Reset during EMIT
        rst64 = 1'b1;
        @(posedge clk); #1;
        rst64 = 1'b0;
        check("w64_rst_bdo_valid", bdo_valid64, 1'b0);
        check("w64_rst_bdi_ready", bdi_ready64, 1'b1);
        check("w64_rst_blk_valid", blk_valid64, 1'b0);

        // Counters cleared: single-word AD block starts at slot 0
        send64(64'h1122334455667788, 4'd8, 1'b1, 4'b0001);
        check("w64_post_rst_blk", blk64, 128'h1122334455667788_8000000000000000);
        check("w64_post_rst_bytes", blk_bytes64, 5'd8);
        blk_ready64 = 1'b1;
        @(posedge clk); #1;
        blk_ready64 = 1'b0;
        check("w64_post_rst_no_bdo", bdo_valid64, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/spoc_block_assembler.md
Name: spoc_block_assembler

Overview:
Parametrised input and output block unit for the SpoC datapath family. It replaces the fixed 64-bit bdi register, padding and truncation logic with one block that serves both SpoC-64 (8-byte rate) and SpoC-128 (16-byte rate) at 32- or 64-bit public widths.
- Input side: collects PW-bit words into one rate block and applies 10* padding.
- Decrypt: recovers plaintext for absorption.
- Output side: streams truncated ciphertext or plaintext words back out under valid/ready handshakes.
- Sits between the pre-processor bdi stream and the permutation state register.

Parameters:
PW, 32, public data width in bits (32 or 64)
RATE_BYTES, 8, rate block size in bytes (8 = SpoC-64, 16 = SpoC-128); must be a multiple of PW/8
WORDS (local), RATE_BYTES*8/PW, words per block
SZW (local), $clog2(PW/8)+1, width of byte-size fields

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
bdi  in  PW  input word, MSB-first bytes
bdi_valid  in  1  input word valid
bdi_ready  out  1  input word accepted when valid&ready
bdi_size  in  SZW  valid bytes in word (0..PW/8), left-aligned
bdi_eot  in  1  last word of segment
bdi_type  in  4  segment type (AD=0001, PT=0100, CT=0101)
decrypt  in  1  1 = CT in / PT out
ks  in  RATE_BYTES*8  rate portion of state (keystream), stable while blk_valid
blk  out  RATE_BYTES*8  padded block to absorb
blk_valid  out  1  block ready to absorb
blk_ready  in  1  datapath absorbs block
blk_partial  out  1  block_bytes < RATE_BYTES
blk_bytes  out  $clog2(RATE_BYTES)+1  data bytes in block
blk_type  out  4  type latched on first word of block
bdo  out  PW  output word
bdo_valid  out  1  output word valid
bdo_ready  in  1  output word consumed
bdo_size  out  SZW  valid bytes in bdo

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active high.
- Reset state: FILL. Buffer, word_ctr, byte_ctr, out_ctr all 0. Outputs: bdi_ready=1, blk_valid=0, bdo_valid=0, bdo=0, bdo_size=0.
- A reset in any state aborts the operation; the next cycle is FILL with cleared counters.
- Type classes: MSG = bdi_type[3:1]==3'b010. All other types are absorb-only.
- FILL state:
  - bdi_ready=1.
  - On a handshake, the word is written into buffer slot word_ctr (slot 0 = MSB). Bytes beyond bdi_size are zeroed.
  - byte_ctr += bdi_size. blk_type is latched when word_ctr==0.
  - Go to HOLD on the next edge if bdi_eot=1 or word_ctr==WORDS-1. word_ctr then wraps to 0.
  - Otherwise word_ctr += 1.
  - A full block without eot ends the block (blk_partial=0). The following words open a new block with the same type.
- HOLD state:
  - blk_valid=1, bdi_ready=0. Latency from the last-word handshake to blk_valid is 1 cycle.
  - data = buffer if decrypt=0 or type is not MSG; otherwise data = buffer ^ (ks & mask), where mask = ones in the first byte_ctr bytes.
  - blk = data with byte index byte_ctr set to 0x80 and the rest zero when byte_ctr < RATE_BYTES; blk = data unpadded when full.
  - blk, blk_bytes and blk_partial are held stable until the handshake.
  - On blk_valid & blk_ready, for a MSG type with byte_ctr > 0: latch out_reg = buffer ^ (ks & mask), then go to EMIT.
  - On blk_valid & blk_ready otherwise (including MSG with byte_ctr==0): clear byte_ctr and go to FILL.
- EMIT state:
  - bdo_valid=1. bdo = out_reg word out_ctr, with bytes beyond bdo_size zeroed.
  - bdo_size = min(PW/8, byte_ctr - out_ctr*PW/8).
  - On a handshake, out_ctr += 1. After the last word (ceil(byte_ctr/(PW/8)) words), clear the counters and go to FILL.
  - out_reg is independent of ks, so the datapath may overwrite state during EMIT.
- Simultaneous events: blk_ready without blk_valid is ignored. bdi_valid is ignored outside FILL.
- Illegal input: bdi_size > PW/8 is unsupported; it is flagged only by a bench assertion.
- Empty segment: a word with bdi_size=0 and eot=1 gives a pad-only block (blk = 0x80 then zeros, blk_bytes=0) and no output words.

Test Plan:
- PW=32, R=8, AD: 0x01020304/4, 0x05060708/4 with eot -> blk=0x0102030405060708, blk_partial=0, blk_bytes=8, bdo_valid never 1.
- AD partial: 0xAABBCCDD/3 with eot -> blk=0xAABBCC8000000000, blk_partial=1, blk_bytes=3, blk_valid 1 cycle after the handshake.
- PT encrypt, ks=0xF0F0F0F00F0F0F0F: 0x11223344/4, 0x55000000/1 with eot -> blk=0x1122334455800000; bdo=0xE1D2C3B4/4, then 0x5A000000/1.
- CT decrypt, same ks: 0xE1D2C3B4/4, 0x5A000000/1 with eot, decrypt=1 -> blk=0x1122334455800000; bdo=0x11223344/4, then 0x55000000/1.
- Empty PT (size 0, eot) -> blk=0x8000000000000000, blk_bytes=0, no bdo_valid, bdi_ready=1 the cycle after blk handshake.
- PW=64, R=16, stalls and reset:
  - Three 8-byte PT words without eot: the first block closes after 2 words; the third word starts a new block.
  - blk_ready=0 for 5 cycles: blk stays stable and bdi_ready=0.
  - rst during EMIT: next cycle bdo_valid=0, bdi_ready=1.
